// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer: FSM state encoding and default accumulator width.
package mac_pkg;

  localparam int unsigned ACC_W_DEFAULT = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mac_sequencer_mult.sv
// 8x8 multiplier, signed or unsigned, 16-bit product.
//   a, b        : operands
//   signed_mode : 1 = two's-complement operands
//   p           : product
module configurable_multiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        signed_mode,
  output logic [15:0] p
);

  logic [15:0] a_ext;
  logic [15:0] b_ext;

  // The low 16 bits of the product of the 16-bit extended operands are the exact
  // 8x8 product in either mode, so one multiplier serves both.
  always_comb begin
    a_ext = signed_mode ? {{8{a[7]}}, a} : {8'h00, a};
    b_ext = signed_mode ? {{8{b[7]}}, b} : {8'h00, b};
    p     = a_ext * b_ext;
  end

endmodule

// File: rtl/mac_sequencer.sv
// Sequenced multiply-accumulate over a stream of operand pairs.
//   start/len/signed_mode/acc_keep : job request, sampled in IDLE
//   abort                          : cancel a running job
//   in_valid/in_ready/in0/in1      : operand stream
//   busy/done                      : job status, done is a one-cycle pulse
//   acc_out/ovf                    : accumulator and sticky overflow flag
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       len,
  input  logic             signed_mode,
  input  logic             acc_keep,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in0,
  input  logic [7:0]       in1,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf
);

  state_e           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       count_q, count_d;
  logic [7:0]       op0_q, op0_d;
  logic [7:0]       op1_q, op1_d;
  logic             signed_q, signed_d;
  logic             s1_valid_q, s1_valid_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  logic [15:0]      prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   sum;
  logic             add_ovf;
  logic             hs;

  configurable_multiplier u_mult (
    .a           (op0_q),
    .b           (op1_q),
    .signed_mode (signed_q),
    .p           (prod)
  );

  always_comb begin
    in_ready = (state_q == RUN) && (count_q < len_q);
    // abort wins over a coincident handshake: the pair is not consumed
    hs       = in_valid && in_ready && !abort;

    prod_ext = signed_q ? {{(ACC_W-16){prod[15]}}, prod} : {{(ACC_W-16){1'b0}}, prod};
    sum      = {1'b0, acc_q} + {1'b0, prod_ext};
    add_ovf  = signed_q ? ((acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                           (sum[ACC_W-1] != acc_q[ACC_W-1]))
                        : sum[ACC_W];

    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    signed_d   = signed_q;
    op0_d      = hs ? in0 : op0_q;
    op1_d      = hs ? in1 : op1_q;
    s1_valid_d = hs;
    acc_d      = acc_q;
    ovf_d      = ovf_q;

    // Stage 2 runs independently of the FSM so an in-flight product survives abort.
    if (s1_valid_q) begin
      acc_d = sum[ACC_W-1:0];
      if (add_ovf) ovf_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = len;
          signed_d = signed_mode;
          count_d  = '0;
          if (!acc_keep) begin
            acc_d = '0;
            ovf_d = 1'b0;
          end
          state_d = (len == 8'd0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (hs) begin
          count_d = count_q + 8'd1;
          if (count_q + 8'd1 == len_q) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      count_q    <= '0;
      op0_q      <= '0;
      op1_q      <= '0;
      signed_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      op0_q      <= op0_d;
      op1_q      <= op1_d;
      signed_q   <= signed_d;
      s1_valid_q <= s1_valid_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    acc_out = acc_q;
    ovf     = ovf_q;
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench: two instances (default width and ACC_W=17) share one stimulus stream.
module tb_mac_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        signed_mode;
  logic        acc_keep;
  logic        abort;
  logic        in_valid;
  logic [7:0]  in0;
  logic [7:0]  in1;

  logic        in_ready_a, busy_a, done_a, ovf_a;
  logic [23:0] acc_a;
  logic        in_ready_b, busy_b, done_b, ovf_b;
  logic [16:0] acc_b;

  typedef struct packed {
    logic [31:0] acc;
    logic        ovf;
  } exp_t;

  exp_t  q_a[$];
  exp_t  q_b[$];
  string qn_a[$];
  string qn_b[$];

  int n_vec = 0;
  int n_miss = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  logic [7:0] pa [0:7];
  logic [7:0] pb [0:7];

  mac_sequencer u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .signed_mode(signed_mode),
    .acc_keep(acc_keep), .abort(abort), .in_valid(in_valid), .in_ready(in_ready_a),
    .in0(in0), .in1(in1), .busy(busy_a), .done(done_a), .acc_out(acc_a), .ovf(ovf_a)
  );

  mac_sequencer #(.ACC_W(17)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .signed_mode(signed_mode),
    .acc_keep(acc_keep), .abort(abort), .in_valid(in_valid), .in_ready(in_ready_b),
    .in0(in0), .in1(in1), .busy(busy_b), .done(done_b), .acc_out(acc_b), .ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Monitor: pop the expected result whenever a DUT signals done.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (done_a === 1'b1) begin
      done_cnt_a++;
      if (q_a.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_done_w24: done=1 with no job expected");
      end else begin
        e  = q_a.pop_front();
        nm = qn_a.pop_front();
        chk({nm, "_acc_w24"}, {8'h00, acc_a}, e.acc);
        chk({nm, "_ovf_w24"}, {31'h0, ovf_a}, {31'h0, e.ovf});
      end
    end
    if (done_b === 1'b1) begin
      done_cnt_b++;
      if (q_b.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_done_w17: done=1 with no job expected");
      end else begin
        e  = q_b.pop_front();
        nm = qn_b.pop_front();
        chk({nm, "_acc_w17"}, {15'h0, acc_b}, e.acc);
        chk({nm, "_ovf_w17"}, {31'h0, ovf_b}, {31'h0, e.ovf});
      end
    end
  end

  task automatic check_all_zero(input string nm);
    chk({nm, "_acc_w24"},   {8'h00, acc_a}, 32'd0);
    chk({nm, "_ovf_w24"},   {31'h0, ovf_a}, 32'd0);
    chk({nm, "_busy_w24"},  {31'h0, busy_a}, 32'd0);
    chk({nm, "_done_w24"},  {31'h0, done_a}, 32'd0);
    chk({nm, "_ready_w24"}, {31'h0, in_ready_a}, 32'd0);
    chk({nm, "_acc_w17"},   {15'h0, acc_b}, 32'd0);
    chk({nm, "_ovf_w17"},   {31'h0, ovf_b}, 32'd0);
    chk({nm, "_busy_w17"},  {31'h0, busy_b}, 32'd0);
    chk({nm, "_done_w17"},  {31'h0, done_b}, 32'd0);
    chk({nm, "_ready_w17"}, {31'h0, in_ready_b}, 32'd0);
  endtask

  // Called just after a rising edge. gap: in_valid toggles every other cycle.
  // hold: start stays high (with different job fields) while the job runs.
  task automatic run_job(input string nm, input int unsigned l, input logic s, input logic k,
                         input logic gap, input logic hold,
                         input logic [31:0] ea, input logic oa,
                         input logic [31:0] eb, input logic ob);
    int unsigned i, tmo, n;
    logic hs, tog;
    q_a.push_back('{acc: ea, ovf: oa});
    q_b.push_back('{acc: eb, ovf: ob});
    qn_a.push_back(nm);
    qn_b.push_back(nm);
    start = 1'b1; len = l[7:0]; signed_mode = s; acc_keep = k;
    @(posedge clk); #1;
    start = hold;
    if (hold) begin
      len = 8'd0; signed_mode = ~s; acc_keep = ~k;
    end
    i = 0; tmo = 0; tog = 1'b0;
    while (i < l && tmo < 200) begin
      if (gap && tog) begin
        in_valid = 1'b0; in0 = 8'hAA; in1 = 8'h55;
      end else begin
        in_valid = 1'b1; in0 = pa[i]; in1 = pb[i];
      end
      tog = ~tog;
      @(negedge clk);
      hs = in_valid && in_ready_a;
      @(posedge clk); #1;
      if (hs) i++;
      tmo++;
    end
    chk({nm, "_pairs_taken"}, i, l);
    start = 1'b0;
    // junk offered while not ready must be ignored
    in_valid = 1'b1; in0 = 8'hFF; in1 = 8'hFF;
    n = 0;
    while (done_a !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done_latency"}, n, 32'd2);
    chk({nm, "_busy_at_done"}, {31'h0, busy_a}, 32'd1);
    @(negedge clk);
    chk({nm, "_busy_after"}, {31'h0, busy_a}, 32'd0);
    chk({nm, "_done_after"}, {31'h0, done_a}, 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int d0a, d0b;
    rst_n = 1'b0; start = 1'b0; len = 8'd0; signed_mode = 1'b0; acc_keep = 1'b0;
    abort = 1'b0; in_valid = 1'b0; in0 = 8'd0; in1 = 8'd0;
    #2;
    check_all_zero("reset");
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    pa[0] = 8'd2;   pb[0] = 8'd3;
    pa[1] = 8'd4;   pb[1] = 8'd5;
    pa[2] = 8'd255; pb[2] = 8'd255;
    run_job("unsigned3", 3, 1'b0, 1'b0, 1'b0, 1'b0, 32'd65051, 1'b0, 32'd65051, 1'b0);

    pa[0] = 8'hFF; pb[0] = 8'h02;
    pa[1] = 8'h80; pb[1] = 8'h80;
    run_job("signed2", 2, 1'b1, 1'b0, 1'b0, 1'b0, 32'd16382, 1'b0, 32'd16382, 1'b0);

    run_job("len0", 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

    pa[0] = 8'd255; pb[0] = 8'd255;
    pa[1] = 8'd255; pb[1] = 8'd255;
    run_job("ff_x2", 2, 1'b0, 1'b0, 1'b0, 1'b0, 32'd130050, 1'b0, 32'd130050, 1'b0);
    run_job("ff_keep", 1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd195075, 1'b0, 32'd64003, 1'b1);
    run_job("ovf_sticky", 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd195075, 1'b0, 32'd64003, 1'b1);

    for (int i = 0; i < 4; i++) begin
      pa[i] = 8'd1; pb[i] = 8'd1;
    end
    run_job("backpressure", 4, 1'b0, 1'b0, 1'b1, 1'b1, 32'd4, 1'b0, 32'd4, 1'b0);

    for (int i = 0; i < 4; i++) begin
      pa[i] = 8'h80; pb[i] = 8'h80;
    end
    run_job("signed_ovf", 4, 1'b1, 1'b0, 1'b0, 1'b0, 32'd65536, 1'b0, 32'd65536, 1'b1);

    // abort after one pair; the coincident offered pair must not be taken
    d0a = done_cnt_a; d0b = done_cnt_b;
    start = 1'b1; len = 8'd3; signed_mode = 1'b0; acc_keep = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in0 = 8'd3; in1 = 8'd3;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'h0, busy_a}, 32'd0);
    chk("abort_acc_w24", {8'h00, acc_a}, 32'd9);
    chk("abort_acc_w17", {15'h0, acc_b}, 32'd9);
    repeat (4) @(negedge clk);
    chk("abort_acc_stable", {8'h00, acc_a}, 32'd9);
    chk("abort_no_done_w24", done_cnt_a - d0a, 32'd0);
    chk("abort_no_done_w17", done_cnt_b - d0b, 32'd0);

    // reset in the middle of a running job
    @(posedge clk); #1;
    d0a = done_cnt_a; d0b = done_cnt_b;
    start = 1'b1; len = 8'd3; signed_mode = 1'b0; acc_keep = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in0 = 8'd5; in1 = 8'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_acc", {8'h00, acc_a}, 32'd25);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_no_done_w24", done_cnt_a - d0a, 32'd0);
    chk("reset_no_done_w17", done_cnt_b - d0b, 32'd0);
    @(posedge clk); #1;

    pa[0] = 8'd7; pb[0] = 8'd8;
    run_job("after_reset", 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd56, 1'b0, 32'd56, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q_a.size() + q_b.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter ACC_W, default 24, setting the accumulator width in bits (legal range 17..32).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all flops are rising-edge.
REQ-003 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit, a job request, sampled only in IDLE.
REQ-005 SHALL have port len, input, 8 bits, the number of operand pairs in the job, sampled with start.
REQ-006 SHALL have port signed_mode, input, 1 bit, 1 = two's-complement operands, sampled with start.
REQ-007 SHALL have port acc_keep, input, 1 bit, 1 = continue from the current accumulator, 0 = clear it; sampled with start.
REQ-008 SHALL have port abort, input, 1 bit, a synchronous job cancel.
REQ-009 SHALL have ports in_valid (input, 1 bit), in_ready (output, 1 bit), in0 (input, 8 bits) and in1 (input, 8 bits), forming the operand stream.
REQ-010 SHALL have port busy, output, 1 bit, high in any state except IDLE.
REQ-011 SHALL have port done, output, 1 bit, a one-cycle job-complete pulse.
REQ-012 SHALL have ports acc_out (output, ACC_W bits), the accumulator, and ovf (output, 1 bit), the sticky overflow flag.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-014 FSM transitions SHALL be:
- IDLE -> RUN when start=1 and len!=0.
- IDLE -> DRAIN when start=1 and len=0; no products are taken.
- RUN -> DRAIN on the handshake of pair number len.
- DRAIN -> DONE after exactly 1 cycle.
- DONE -> IDLE after 1 cycle.
REQ-015 A handshake SHALL occur when in_valid=1 and in_ready=1 on a clock edge; in_ready SHALL be 1 only in RUN while count<len.
REQ-016 An 8-bit pair counter SHALL clear on job start and increment on each handshake.
REQ-017 Stage 1: each handshake SHALL register in0/in1 into the operand registers and set an internal stage valid.
REQ-018 Stage 2: on the next edge the registered product SHALL be added to the accumulator; acc_out therefore updates 2 edges after the handshake.
REQ-019 Stage 2 SHALL sign-extend the 16-bit product to ACC_W when the job is signed, and zero-extend it otherwise.
REQ-020 Accumulation SHALL wrap modulo 2^ACC_W.
REQ-021 ovf SHALL be set on any add that causes signed overflow (signed job) or an unsigned carry-out (unsigned job).
REQ-022 ovf SHALL clear only on a job start with acc_keep=0, or on reset.
REQ-023 On job start with acc_keep=0, acc_out SHALL become 0 on the start edge; with acc_keep=1, acc_out SHALL be held.
REQ-024 done SHALL be high only in DONE, and acc_out SHALL be final when done=1.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 in_valid while in_ready=0 SHALL be ignored and no operands SHALL be consumed.
REQ-027 in_valid gaps in RUN SHALL stall the FSM with no timeout.
REQ-028 abort=1 in RUN SHALL return the FSM to IDLE next edge with no done pulse; an in-flight stage-2 product SHALL still be accumulated; abort SHALL have priority over a simultaneous handshake, which is not consumed.
REQ-029 abort in IDLE, DRAIN or DONE SHALL have no effect.

Reset
REQ-030 rst_n=0 SHALL force state IDLE, with counter, operand registers, stage valid, acc_out, ovf, done and in_ready all 0 and busy 0, regardless of clk.
REQ-031 Reset mid-job SHALL discard the job, with no done pulse after release.

Structure
REQ-032 The FSM state encoding and the ACC_W default SHALL live in shared package mac_pkg.
REQ-033 The block SHALL instantiate exactly one configurable_multiplier, fed by the operand registers and the latched signed_mode, and SHALL contain no other multiplier.

Verification
REQ-034 Unsigned, len=3, pairs (2,3),(4,5),(255,255) -> acc_out=65051 (0x00FE1B), ovf=0, done one cycle after DRAIN.
REQ-035 Signed, len=2, pairs (0xFF,0x02),(0x80,0x80) -> acc_out=16382 (0x003FFE), ovf=0.
REQ-036 len=0 with start -> busy for 2 cycles, done pulses, acc_out=0.
REQ-037 With ACC_W=17: unsigned (255,255)x2 then a second job with acc_keep=1 and (255,255) -> acc_out=64003, ovf=1.
REQ-038 Backpressure: in_valid toggling every other cycle, len=4, all pairs (1,1) -> acc_out=4, no pair lost or duplicated.
REQ-039 abort after 1 of 3 pairs (3,3) -> acc_out=9, no done pulse.
REQ-040 rst_n low mid-RUN -> all outputs 0 immediately; a new job after release completes correctly.
